// File: rtl/seven_seg_capture_if.sv
// Seven-segment display bus as seen at the pins: scan inputs plus the
// reassembled value and status pulses produced by the capture block.
interface seven_seg_capture_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        valid;
  logic        seg_err;
  logic        an_err;

  modport master (
    output seg, an,
    input  value, valid, seg_err, an_err
  );

  modport slave (
    input  seg, an,
    output value, valid, seg_err, an_err
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus: filters
// scan transitions, decodes stable glyphs and reassembles the 16-bit value.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_capture_if.slave  bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned VAL_W = 16;

  logic [AN_W-1:0]  r_an, r_an_d;
  logic [SEG_W-1:0] r_seg, r_seg_d;
  logic [CNT_W-1:0] r_cnt;
  logic [VAL_W-1:0] r_shadow;
  logic [VAL_W-1:0] r_value;
  logic [AN_W-1:0]  r_seen;
  logic             r_valid;
  logic             r_seg_err;
  logic             r_an_err;

  logic             w_changed;
  logic             w_act;
  logic [4:0]       w_glyph;
  logic             w_seg_ok;
  logic             w_onehot;
  logic             w_blank;
  logic [1:0]       w_idx;
  logic             w_cap;
  logic             w_frame;
  logic [VAL_W-1:0] w_shadow_next;
  logic [AN_W-1:0]  w_seen_next;

  // Returns {match, nibble}; only exact glyph patterns are accepted.
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    logic [4:0] d;
    case (s)
      7'b1000000: d = 5'h10;
      7'b1111001: d = 5'h11;
      7'b0100100: d = 5'h12;
      7'b0110000: d = 5'h13;
      7'b0011001: d = 5'h14;
      7'b0010010: d = 5'h15;
      7'b0000010: d = 5'h16;
      7'b1111000: d = 5'h17;
      7'b0000000: d = 5'h18;
      7'b0010000: d = 5'h19;
      7'b0001000: d = 5'h1A;
      7'b0000011: d = 5'h1B;
      7'b1000110: d = 5'h1C;
      7'b0100001: d = 5'h1D;
      7'b0000110: d = 5'h1E;
      7'b0001110: d = 5'h1F;
      default:    d = 5'h00;
    endcase
    return d;
  endfunction

  always_comb begin
    w_changed     = {r_an, r_seg} != {r_an_d, r_seg_d};
    // Fire once, on the edge where the run length reaches STABLE_CYCLES.
    w_act         = w_changed ? (STABLE_CYCLES == 1)
                              : (r_cnt == CNT_W'(STABLE_CYCLES - 1));
    w_glyph       = glyph_decode(r_seg);
    w_seg_ok      = w_glyph[4];
    w_onehot      = $onehot(~r_an);
    w_blank       = &r_an;
    case (r_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
    w_cap         = w_act && w_onehot && w_seg_ok;
    w_shadow_next = r_shadow;
    w_shadow_next[{w_idx, 2'b00} +: 4] = w_glyph[3:0];
    w_seen_next   = r_seen | AN_W'(4'b0001 << w_idx);
    w_frame       = w_cap && (&w_seen_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an      <= '1;
      r_seg     <= '1;
      r_an_d    <= '1;
      r_seg_d   <= '1;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_seen    <= '0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_seg_err <= 1'b0;
      r_an_err  <= 1'b0;
    end else begin
      r_an    <= bus.an;
      r_seg   <= bus.seg;
      r_an_d  <= r_an;
      r_seg_d <= r_seg;

      if (w_changed)
        r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);

      r_valid   <= w_frame;
      r_seg_err <= w_act && w_onehot && !w_seg_ok;
      r_an_err  <= w_act && !w_onehot && !w_blank;

      if (w_cap) begin
        r_shadow <= w_shadow_next;
        r_seen   <= w_frame ? '0 : w_seen_next;
      end
      if (w_frame)
        r_value <= w_shadow_next;
    end
  end

  assign bus.value   = r_value;
  assign bus.valid   = r_valid;
  assign bus.seg_err = r_seg_err;
  assign bus.an_err  = r_an_err;

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side decoder for the board's multiplexed four-digit seven-segment bus. It samples the active-low segment and anode lines, filters scan transitions and glitches, and decodes each stable digit pattern back to a hex nibble. It reassembles the 16-bit value that was being displayed. It sits on the monitoring/loopback path, opposite the display driver, so a lab datapath result can be checked from what actually reached the display pins.

## Interface
- STABLE_CYCLES, 4, number of consecutive clock edges a sampled {an, seg} pair must be unchanged before it is captured; legal range 1..255
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- seg  input  7  segment lines g..a (bit 6 = g, bit 0 = a); active-low (0 = lit)
- an  input  4  digit anodes; active-low; an[i]=0 selects digit i (digit 0 = value[3:0])
- value  output  16  last fully reassembled display value
- valid  output  1  one-cycle pulse: value was just updated with a complete frame
- seg_err  output  1  one-cycle pulse: a stable digit pattern matched no hex glyph
- an_err  output  1  one-cycle pulse: a stable anode pattern was neither one-hot-low nor all-ones

## Operation
- Glyph table, seg[6:0] per hex digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Exact match is required; any other pattern is invalid.
- Input stage: seg and an are registered once before any comparison. Its reset value is the blank pattern, an=1111 and seg=1111111.
- Run counter: 8-bit, saturating. It restarts when the registered pair differs from its previous value and counts edges the pair has held.
- Each stable run is acted on exactly once, when it reaches STABLE_CYCLES. Nothing further happens until the pair changes. A later identical run after any different interim pair is acted on again.
- Action on the captured pair:
  - an one-hot-low at index i, seg valid: shadow[i] = decoded nibble, seen[i] set.
  - an one-hot-low, seg invalid: seg_err pulse. shadow[i] and seen[i] are unchanged.
  - an = 1111 (blanking interval): no action, no error.
  - Any other an: an_err pulse. seg is ignored.
- Frame completion: when a valid capture makes seen = 1111, the following happen in the same update:
  - value is loaded from shadow, including the nibble just decoded.
  - valid pulses.
  - seen clears to 0000.
- Digit order is irrelevant. A repeat capture of a digit already seen overwrites shadow[i] and does not complete a frame.
- value holds between frames. seg_err and an_err never affect value.

## Timing
- A pair present on the inputs steadily from just before edge E is acted on at edge E+STABLE_CYCLES. With STABLE_CYCLES=1 that is edge E+1.
- valid, seg_err and an_err are registered, high for exactly one cycle, and never high together.
- Reset (rst=0) takes effect immediately, regardless of clk. It clears:
  - value = 0x0000
  - valid = seg_err = an_err = 0
  - shadow, seen and the run counter to 0
  - the input stage to blank
- A partial frame interrupted by reset is discarded. After rst returns high, the first capture can occur at E+STABLE_CYCLES, where E is the first edge with rst=1.
- A pair held shorter than STABLE_CYCLES edges produces no action and no error.

## Test plan
- Reset mid-frame: capture digits 0–1 of 0x1234, assert rst between edges. Required: all outputs 0 at once, without waiting for an edge. After release, scan digits 2–3 only. Required: no valid.
- Full frame, STABLE_CYCLES=4, each digit held 8 cycles: an=1110/seg=0011001, an=1101/seg=0110000, an=1011/seg=0100100, an=0111/seg=1111001. Required: exactly one valid pulse, value=0x1234, at edge E+4 of the last digit.
- Glitch filter, STABLE_CYCLES=4: an=1110/seg=1111000 held 3 edges, then 4 edges. Required: nothing on the first hold. The second hold captures 7 into digit 0.
- Bad glyph: an=1101/seg=1111111 held 6 cycles inside a frame. Required: one seg_err pulse, no valid, value unchanged. Re-scanning digit 1 with a legal glyph then completes the frame.
- Anode checks: an=1100 held 5 cycles gives one an_err pulse. an=1111 held 20 cycles gives no pulse of any kind.
- Continuous scan of 0xABCD, digits 0→3, 6 cycles each, with 2-cycle blanks between, for 5 rotations. Required: exactly 5 valid pulses, value=0xABCD, no error pulses.
